mem_seq_ctrl: RTL and testbench
===============================

Name: mem_seq_ctrl

Overview:
- Memory sequencer directly upstream of the 32x8 single-port data RAM (clock, WE, address, Input, registered Output).
- Accepts single read, single write, block copy and block fill commands from the processor datapath over a req/busy/done handshake.
- Drives the RAM port and compensates for its one-cycle registered read latency.
- The RAM's async preset (cheat) is not driven by this block.

Parameters:
- AW, 5, RAM address width; depth = 2**AW.
- DW, 8, RAM data width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  command request, sampled only in IDLE.
- op  in  2  00 read, 01 write, 10 copy, 11 fill.
- addr  in  AW  read/write address; source address for copy; start address for fill.
- dst  in  AW  copy destination start address.
- len  in  AW  block length for copy/fill; 0 means 2**AW words.
- wdata  in  DW  write data; fill pattern.
- busy  out  1  high from the cycle after acceptance until done.
- done  out  1  one-cycle completion pulse.
- rdata  out  DW  read result; holds until the next read completes.
- ram_WE  out  1  to RAM WE.
- ram_address  out  AW  to RAM address.
- ram_Input  out  DW  to RAM Input.
- ram_Output  in  DW  from RAM Output.

Behaviour:
- Reset (async, level): state=IDLE; busy=0, done=0, rdata=0, ram_WE=0, ram_address=0, ram_Input=0; all internal counters and buffers = 0.
- Reset mid-command aborts immediately; RAM writes already performed remain and are not rolled back.
- FSM states: IDLE, RD, RD_WAIT, WR, C_RD, C_WAIT, C_WR, F_WR, DONE.
- IDLE: ram_WE=0. On req=1 at edge E0, latch op, addr, dst, wdata and len into registers; go to RD, WR, C_RD or F_WR by op; busy=1.
- In any state other than IDLE, req is ignored and the latched operands are frozen.
- RD: ram_address=addr, ram_WE=0. At E1 the RAM registers its Output; go to RD_WAIT.
- RD_WAIT: address is held. At E2, rdata<=ram_Output; go to DONE.
- WR: ram_WE=1, ram_address=addr, ram_Input=wdata. The RAM writes at E1; go to DONE.
- Copy, per word i (src=addr+i, dst=dst+i; both wrap modulo 2**AW):
  - C_RD: read src.
  - C_WAIT: hold src; at the edge, buf<=ram_Output.
  - C_WR: write buf to dst.
  - After C_WR, decrement remaining; if remaining=0 go to DONE, else go to C_RD.
  - Cost is 3 cycles/word. Overlapping ranges copy in ascending order with no hazard protection.
- Fill: F_WR writes wdata to addr+i (wraps), 1 cycle/word; go to DONE after the last word.
- Remaining counter is AW+1 bits, loaded with (len==0 ? 2**AW : len).
- DONE: done=1 for exactly one cycle, busy=0, ram_WE=0; return to IDLE. A req present in this cycle is ignored; it is accepted next cycle in IDLE.
- Latency (acceptance edge to the done-high cycle): read = 3 edges, write = 2, copy = 3*N+1, fill = N+1.
- ram_WE is high only in WR, C_WR and F_WR.
- ram_address and ram_Input are decoded from registered state and counters only; there is no combinational path from the command inputs to the RAM.
- rdata changes only on read completion; copy does not update rdata.

Decomposition:
- Shared package mem_pkg holds:
  - op encodings OP_RD, OP_WR, OP_CPY, OP_FILL;
  - FSM state encoding;
  - AW/DW defaults.
- One sub-module, blk_addr_gen: the remaining down-counter plus the wrapped src/dst offset adders, shared by copy and fill.

Test Plan:
- Reset -> all outputs 0; assert reset mid-fill at word 2 -> outputs return to 0 immediately, words 0-1 written, word 2 and later untouched.
- Write 0x5A to addr 3, then read addr 3 -> rdata=0x5A with done exactly 3 edges after acceptance; write done exactly 2 edges after acceptance.
- Preset the RAM, then copy addr=0, dst=10, len=4 -> mem[10..13]=170,1,2,3; done exactly 13 edges after acceptance; rdata unchanged.
- Fill addr=30, len=4, wdata=0xFF -> mem[30],[31],[0],[1]=0xFF (wrap); mem[2]=2 unchanged.
- Fill len=0, wdata=0x00 -> all 32 words 0; done exactly 33 edges after acceptance.
- req pulsed with op=write while busy, and during the DONE cycle -> ignored, no extra RAM write; a req held into IDLE is accepted once.

Source files
------------

// File: rtl/mem_pkg.sv
// Purpose: shared op codes, FSM state encoding and width defaults for the memory sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_pkg;

    localparam int AW_DEF = 5;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        OP_RD   = 2'b00,
        OP_WR   = 2'b01,
        OP_CPY  = 2'b10,
        OP_FILL = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_C_RD,
        S_C_WAIT,
        S_C_WR,
        S_F_WR,
        S_DONE
    } state_e;

    // Copy and fill are the two multi-word commands; both have op[1] set.
    function automatic logic is_blk(input op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mem_seq_ctrl_if.sv
// Purpose: command handshake between processor datapath and memory sequencer.
// Latency: n/a (wires only).
// Backpressure: master holds off new requests while busy or done is high.
// Ports: req/op/addr/dst/len/wdata driven by master; busy/done/rdata driven by slave.
interface mem_seq_ctrl_if
    import mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          req;
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [AW-1:0] dst;
    logic [AW-1:0] len;
    logic [DW-1:0] wdata;
    logic          busy;
    logic          done;
    logic [DW-1:0] rdata;

    modport master (
        output req, op, addr, dst, len, wdata,
        input  busy, done, rdata
    );

    modport slave (
        input  req, op, addr, dst, len, wdata,
        output busy, done, rdata
    );
endinterface

// File: rtl/blk_addr_gen.sv
// Purpose: remaining-word down-counter and wrapped src/dst address adders for copy and fill.
// Latency: load/step take effect at the next edge; addresses are combinational from registers.
// Backpressure: none; the sequencer steps it once per word written.
// Ports: ld (with len) restarts the block, step advances one word, last flags the final word.
module blk_addr_gen #(
    parameter int AW = 5
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          ld,
    input  logic          step,
    input  logic [AW-1:0] len,
    input  logic [AW-1:0] src_base,
    input  logic [AW-1:0] dst_base,
    output logic [AW-1:0] src_addr,
    output logic [AW-1:0] dst_addr,
    output logic          last
);
    localparam logic [AW:0] FULL_BLK = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE_W    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] ONE_A  = {{(AW-1){1'b0}}, 1'b1};

    // One extra bit so len==0 can stand for a whole-memory block.
    logic [AW:0]   remaining;
    logic [AW-1:0] offset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            remaining <= '0;
            offset    <= '0;
        end else if (ld) begin
            remaining <= (len == '0) ? FULL_BLK : {1'b0, len};
            offset    <= '0;
        end else if (step) begin
            remaining <= remaining - ONE_W;
            offset    <= offset + ONE_A;
        end
    end

    // Natural AW-bit overflow gives the modulo-depth wrap.
    assign src_addr = src_base + offset;
    assign dst_addr = dst_base + offset;
    assign last     = (remaining == ONE_W);

endmodule

// File: rtl/mem_seq_ctrl.sv
// Purpose: sequences read/write/copy/fill commands onto a single-port RAM with registered output.
// Latency: read 3, write 2, copy 3*N+1, fill N+1 edges from acceptance to done.
// Backpressure: req is only sampled in IDLE; busy/done tell the master when it may issue.
// Ports: clock/reset, cmd (slave side of mem_seq_ctrl_if), ram_WE/ram_address/ram_Input to RAM,
//        ram_Output from RAM.
module mem_seq_ctrl
    import mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clock,
    input  logic          reset,
    mem_seq_ctrl_if.slave cmd,
    output logic          ram_WE,
    output logic [AW-1:0] ram_address,
    output logic [DW-1:0] ram_Input,
    input  logic [DW-1:0] ram_Output
);
    state_e        state;
    logic [AW-1:0] addr_r;
    logic [AW-1:0] dst_r;
    logic [DW-1:0] wdata_r;
    logic [DW-1:0] word_buf;
    logic [DW-1:0] rdata_r;

    logic          ld;
    logic          step;
    logic          last;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;

    // Counter is loaded in the same edge the operands are latched, so the
    // first block word already sees offset 0 against the new base.
    assign ld   = (state == S_IDLE) && cmd.req && is_blk(op_e'(cmd.op));
    assign step = (state == S_C_WR) || (state == S_F_WR);

    blk_addr_gen #(.AW(AW)) u_addr_gen (
        .clock    (clock),
        .reset    (reset),
        .ld       (ld),
        .step     (step),
        .len      (cmd.len),
        .src_base (addr_r),
        .dst_base (dst_r),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .last     (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            addr_r   <= '0;
            dst_r    <= '0;
            wdata_r  <= '0;
            word_buf <= '0;
            rdata_r  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd.req) begin
                        addr_r  <= cmd.addr;
                        dst_r   <= cmd.dst;
                        wdata_r <= cmd.wdata;
                        case (op_e'(cmd.op))
                            OP_RD:   state <= S_RD;
                            OP_WR:   state <= S_WR;
                            OP_CPY:  state <= S_C_RD;
                            default: state <= S_F_WR;
                        endcase
                    end
                end
                S_RD:      state <= S_RD_WAIT;
                // RAM output register now holds the addressed word.
                S_RD_WAIT: begin
                    rdata_r <= ram_Output;
                    state   <= S_DONE;
                end
                S_WR:      state <= S_DONE;
                S_C_RD:    state <= S_C_WAIT;
                S_C_WAIT: begin
                    word_buf <= ram_Output;
                    state    <= S_C_WR;
                end
                S_C_WR:    state <= last ? S_DONE : S_C_RD;
                S_F_WR:    if (last) state <= S_DONE;
                S_DONE:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // RAM port is a pure decode of registered state, operands and counters,
    // so nothing on the command bus reaches the RAM combinationally.
    always_comb begin
        ram_WE      = 1'b0;
        ram_address = '0;
        ram_Input   = '0;
        case (state)
            S_RD, S_RD_WAIT: ram_address = addr_r;
            S_WR: begin
                ram_WE      = 1'b1;
                ram_address = addr_r;
                ram_Input   = wdata_r;
            end
            S_C_RD, S_C_WAIT: ram_address = src_addr;
            S_C_WR: begin
                ram_WE      = 1'b1;
                ram_address = dst_addr;
                ram_Input   = word_buf;
            end
            S_F_WR: begin
                ram_WE      = 1'b1;
                ram_address = src_addr;
                ram_Input   = wdata_r;
            end
            default: ;
        endcase
    end

    assign cmd.busy  = (state != S_IDLE) && (state != S_DONE);
    assign cmd.done  = (state == S_DONE);
    assign cmd.rdata = rdata_r;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Purpose: self-checking bench for mem_seq_ctrl with a 32x8 registered-output RAM model.
// Latency: expected done latency per command is queued at issue and compared at done.
// Backpressure: commands are issued only while the sequencer is neither busy nor done.
`timescale 1ns/1ps
module tb_mem_seq_ctrl;
    import mem_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 8;
    localparam int DEPTH = 32;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ram_WE;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_Input;
    logic [DW-1:0] ram_Output;

    logic [DW-1:0] mem [DEPTH];
    logic          preset = 1'b0;
    int            wr_count = 0;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [DW-1:0] model_rdata = '0;

    typedef struct {
        int            lat;
        logic [DW-1:0] rdata;
    } exp_t;
    exp_t sb[$];

    mem_seq_ctrl_if #(.AW(AW), .DW(DW)) cmd_if ();

    mem_seq_ctrl #(.AW(AW), .DW(DW)) dut (
        .clock       (clock),
        .reset       (reset),
        .cmd         (cmd_if),
        .ram_WE      (ram_WE),
        .ram_address (ram_address),
        .ram_Input   (ram_Input),
        .ram_Output  (ram_Output)
    );

    always #5 clock = ~clock;

    // RAM stand-in: write-port plus registered read output.
    always @(posedge clock) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= DW'(i);
        end else if (ram_WE) begin
            mem[ram_address] <= ram_Input;
            wr_count         <= wr_count + 1;
        end
        ram_Output <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preset_mem();
        @(negedge clock);
        preset = 1'b1;
        @(negedge clock);
        preset = 1'b0;
    endtask

    task automatic push_exp(input logic [1:0] op, input logic [AW-1:0] l, input logic [DW-1:0] rd_exp);
        exp_t e;
        int   n;
        n = (l == '0) ? DEPTH : int'(l);
        case (op)
            2'b00:   e.lat = 3;
            2'b01:   e.lat = 2;
            2'b10:   e.lat = 3 * n + 1;
            default: e.lat = n + 1;
        endcase
        if (op == 2'b00) model_rdata = rd_exp;
        e.rdata = model_rdata;
        sb.push_back(e);
    endtask

    task automatic drive_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [AW-1:0] d,
                             input logic [AW-1:0] l, input logic [DW-1:0] w, input logic [DW-1:0] rd_exp);
        int guard = 0;
        @(negedge clock);
        while ((cmd_if.busy || cmd_if.done) && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        cmd_if.req   = 1'b1;
        cmd_if.op    = op;
        cmd_if.addr  = a;
        cmd_if.dst   = d;
        cmd_if.len   = l;
        cmd_if.wdata = w;
        push_exp(op, l, rd_exp);
        @(posedge clock);
        #1;
        cmd_if.req = 1'b0;
        chk("busy_after_accept", {31'd0, cmd_if.busy}, 32'd1);
    endtask

    // Called #1 after the acceptance edge. With poke set, a write request is
    // thrown at the sequencer every busy cycle and left asserted into DONE.
    task automatic wait_done(input bit poke);
        exp_t e;
        int   edges = 1;
        bit   seen  = 1'b0;
        while (edges < 200) begin
            if (cmd_if.done) begin
                seen = 1'b1;
                break;
            end
            if (poke) begin
                cmd_if.req   = 1'b1;
                cmd_if.op    = 2'b01;
                cmd_if.addr  = 5'd20;
                cmd_if.wdata = 8'h77;
            end
            @(posedge clock);
            #1;
            edges++;
        end
        if (!seen) begin
            chk("done_timeout", 32'd0, 32'd1);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        e = sb.pop_front();
        chk("latency", edges, e.lat);
        chk("rdata", {24'd0, cmd_if.rdata}, {24'd0, e.rdata});
        chk("busy_in_done", {31'd0, cmd_if.busy}, 32'd0);
        if (poke) cmd_if.addr = 5'd21;
        @(posedge clock);
        #1;
        chk("done_one_cycle", {31'd0, cmd_if.done}, 32'd0);
    endtask

    initial begin
        int w0;
        cmd_if.req   = 1'b0;
        cmd_if.op    = 2'b00;
        cmd_if.addr  = '0;
        cmd_if.dst   = '0;
        cmd_if.len   = '0;
        cmd_if.wdata = '0;

        #2;
        chk("rst_busy",  {31'd0, cmd_if.busy}, 32'd0);
        chk("rst_done",  {31'd0, cmd_if.done}, 32'd0);
        chk("rst_rdata", {24'd0, cmd_if.rdata}, 32'd0);
        chk("rst_we",    {31'd0, ram_WE}, 32'd0);
        chk("rst_addr",  {27'd0, ram_address}, 32'd0);
        chk("rst_in",    {24'd0, ram_Input}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        preset_mem();

        // Single write then read-back.
        drive_cmd(OP_WR, 5'd3, 5'd0, 5'd0, 8'h5A, 8'h00);
        wait_done(1'b0);
        chk("wr_mem3", {24'd0, mem[3]}, 32'h5A);
        drive_cmd(OP_RD, 5'd3, 5'd0, 5'd0, 8'h00, 8'h5A);
        wait_done(1'b0);

        // Copy 4 words from 0 to 10; rdata must keep 0x5A.
        preset_mem();
        drive_cmd(OP_WR, 5'd0, 5'd0, 5'd0, 8'd170, 8'h00);
        wait_done(1'b0);
        drive_cmd(OP_CPY, 5'd0, 5'd10, 5'd4, 8'h00, 8'h00);
        wait_done(1'b0);
        chk("cpy_mem10", {24'd0, mem[10]}, 32'd170);
        chk("cpy_mem11", {24'd0, mem[11]}, 32'd1);
        chk("cpy_mem12", {24'd0, mem[12]}, 32'd2);
        chk("cpy_mem13", {24'd0, mem[13]}, 32'd3);
        chk("cpy_mem14", {24'd0, mem[14]}, 32'd14);
        chk("cpy_mem9",  {24'd0, mem[9]},  32'd9);

        // Fill wrapping past the top of memory.
        drive_cmd(OP_FILL, 5'd30, 5'd0, 5'd4, 8'hFF, 8'h00);
        wait_done(1'b0);
        chk("fill_mem30", {24'd0, mem[30]}, 32'hFF);
        chk("fill_mem31", {24'd0, mem[31]}, 32'hFF);
        chk("fill_mem0",  {24'd0, mem[0]},  32'hFF);
        chk("fill_mem1",  {24'd0, mem[1]},  32'hFF);
        chk("fill_mem2",  {24'd0, mem[2]},  32'd2);
        chk("fill_mem29", {24'd0, mem[29]}, 32'd29);

        // Requests while busy and in DONE are ignored; one held into IDLE is taken once.
        w0 = wr_count;
        drive_cmd(OP_CPY, 5'd4, 5'd24, 5'd2, 8'h00, 8'h00);
        wait_done(1'b1);
        chk("held_idle_not_busy", {31'd0, cmd_if.busy}, 32'd0);
        push_exp(OP_WR, 5'd0, 8'h00);
        @(posedge clock);
        #1;
        cmd_if.req = 1'b0;
        chk("held_accept_busy", {31'd0, cmd_if.busy}, 32'd1);
        wait_done(1'b0);
        chk("ign_wr_count", wr_count - w0, 32'd3);
        chk("ign_mem24", {24'd0, mem[24]}, 32'd4);
        chk("ign_mem25", {24'd0, mem[25]}, 32'd5);
        chk("ign_mem20", {24'd0, mem[20]}, 32'd20);
        chk("held_mem21", {24'd0, mem[21]}, 32'h77);

        // Whole-memory fill.
        drive_cmd(OP_FILL, 5'd7, 5'd0, 5'd0, 8'h00, 8'h00);
        wait_done(1'b0);
        for (int i = 0; i < DEPTH; i++) chk($sformatf("fill0_mem%0d", i), {24'd0, mem[i]}, 32'd0);

        // Reset during the third fill word.
        preset_mem();
        drive_cmd(OP_FILL, 5'd8, 5'd0, 5'd6, 8'hC3, 8'h00);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("midfill_we", {31'd0, ram_WE}, 32'd1);
        reset = 1'b1;
        #1;
        void'(sb.pop_back());
        model_rdata = '0;
        chk("abort_busy",  {31'd0, cmd_if.busy}, 32'd0);
        chk("abort_done",  {31'd0, cmd_if.done}, 32'd0);
        chk("abort_rdata", {24'd0, cmd_if.rdata}, 32'd0);
        chk("abort_we",    {31'd0, ram_WE}, 32'd0);
        chk("abort_addr",  {27'd0, ram_address}, 32'd0);
        chk("abort_in",    {24'd0, ram_Input}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        chk("abort_mem8",  {24'd0, mem[8]},  32'hC3);
        chk("abort_mem9",  {24'd0, mem[9]},  32'hC3);
        chk("abort_mem10", {24'd0, mem[10]}, 32'd10);
        chk("abort_mem11", {24'd0, mem[11]}, 32'd11);
        chk("abort_mem13", {24'd0, mem[13]}, 32'd13);

        // Sequencer recovers after the abort.
        drive_cmd(OP_RD, 5'd8, 5'd0, 5'd0, 8'h00, 8'hC3);
        wait_done(1'b0);

        chk("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
